// File: rtl/jump_encode.sv
// jump_encode: two-stage J/JAL encoder with ready/valid flow control, error flags and optional
// saturating error counter (define JUMP_ENCODE_ERRCNT_EN). Reset release must be synchronised upstream.
module jump_encode #(
    parameter int ERRCNT_W = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                InValid,
    output logic                InReady,
    input  logic [31:0]         TargetPC,
    input  logic [31:0]         CurrentPC,
    input  logic                Link,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [31:0]         Instruction,
    output logic [1:0]          Error,
    output logic [ERRCNT_W-1:0] ErrCount
);

    localparam int STAGES = 2;

    typedef struct packed {
        logic [29:0] tgt;   // TargetPC[31:2]
        logic        link;
        logic [1:0]  err;
    } s1_t;

    logic [STAGES:1] vld_pipe;
    s1_t             s1;
    logic            s1_adv, s2_adv;
    logic [1:0]      err_in;
    logic [31:0]     instr_nxt;

    assign s2_adv  = !vld_pipe[2] || OutReady;
    assign s1_adv  = !vld_pipe[1] || s2_adv;
    // Gated by Reset so no request is ever offered acceptance while the pipe is held clear
    assign InReady = Reset && s1_adv;

    assign err_in[0] = |TargetPC[1:0];
    assign err_in[1] = TargetPC[31:28] != CurrentPC[31:28];

    // Opcode is 00001x: J when Link=0, JAL when Link=1; any error turns the slot into a NOP
    assign instr_nxt = (s1.err != 2'b00) ? 32'h0000_0000 : {5'b00001, s1.link, s1.tgt[25:0]};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vld_pipe    <= '0;
            s1          <= '0;
            Instruction <= '0;
            Error       <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= InValid;
                if (InValid)
                    s1 <= '{tgt: TargetPC[31:2], link: Link, err: err_in};
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    Instruction <= instr_nxt;
                    Error       <= s1.err;
                end
            end
        end
    end

    assign OutValid = vld_pipe[2];

`ifdef JUMP_ENCODE_ERRCNT_EN
    logic [ERRCNT_W-1:0] errcnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            errcnt <= '0;
        else if (OutValid && OutReady && (Error != 2'b00) && (errcnt != {ERRCNT_W{1'b1}}))
            errcnt <= errcnt + 1'b1;
    end

    assign ErrCount = errcnt;
`else
    assign ErrCount = '0;
`endif

endmodule

// File: tb/tb_jump_encode.sv
// Scoreboard bench for jump_encode: driver pushes model results at acceptance, monitor pops at output transfer.
module tb_jump_encode;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [31:0]   TargetPC = '0;
    logic [31:0]   CurrentPC = '0;
    logic          Link = 1'b0;
    logic          OutValid;
    logic          OutReady = 1'b1;
    logic [31:0]   Instruction;
    logic [1:0]    Error;
    logic [CW-1:0] ErrCount;

    jump_encode #(.ERRCNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .TargetPC(TargetPC), .CurrentPC(CurrentPC), .Link(Link),
        .OutValid(OutValid), .OutReady(OutReady), .Instruction(Instruction),
        .Error(Error), .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] cur;
        logic        link;
        int          acc;
    } req_t;

    req_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_cnt = 0;
    bit          chk_lat = 0;
    bit          rand_mode = 0;
    logic [31:0] last_instr = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: J-format rules applied directly to the request fields
    function automatic logic [1:0] ref_err(input req_t r);
        ref_err = {r.tgt[31:28] != r.cur[31:28], r.tgt[1:0] != 2'b00};
    endfunction

    function automatic logic [31:0] ref_instr(input req_t r);
        logic [5:0] op;
        op = r.link ? 6'b000011 : 6'b000010;
        ref_instr = (ref_err(r) != 2'b00) ? 32'h0 : {op, r.tgt[27:2]};
    endfunction

    // Monitor: samples mid-cycle; a transfer happens at the next rising edge
    initial begin
        bit          prev_stall = 0;
        logic [31:0] prev_instr;
        logic [1:0]  prev_err;
        req_t        r;
        forever begin
            @(negedge Clk);
            #3;
            if (!Reset) begin
                prev_stall = 0;
                continue;
            end
            chk("errcount", 32'(ErrCount), 32'(exp_cnt));
            if (prev_stall) begin
                chk("stall_valid", 32'(OutValid), 32'd1);
                chk("stall_instr", Instruction, prev_instr);
                chk("stall_err", 32'(Error), 32'(prev_err));
            end
            if (q.size() == 0) begin
                chk("no_stale_output", 32'(OutValid), 32'd0);
            end else if (OutValid && OutReady) begin
                r = q.pop_front();
                chk("instr", Instruction, ref_instr(r));
                chk("error", 32'(Error), 32'(ref_err(r)));
                if (ref_err(r) == 2'b00)
                    chk("reconstruct", {r.cur[31:28], Instruction[25:0], 2'b00}, r.tgt);
                if (chk_lat)
                    chk("latency", 32'(cyc - r.acc), 32'd2);
                last_instr = Instruction;
`ifdef JUMP_ENCODE_ERRCNT_EN
                if (ref_err(r) != 2'b00 && exp_cnt < CMAX) exp_cnt++;
`endif
            end
            prev_stall = OutValid && !OutReady;
            prev_instr = Instruction;
            prev_err   = Error;
        end
    end

    always @(negedge Clk) if (rand_mode) OutReady = 1'($urandom_range(0, 1));

    task automatic push(input logic [31:0] t, input logic [31:0] c, input logic l);
        req_t r;
        r.tgt = t; r.cur = c; r.link = l; r.acc = cyc;
        q.push_back(r);
    endtask

    task automatic send(input logic [31:0] t, input logic [31:0] c, input logic l);
        int n = 0;
        bit done = 0;
        while (!done) begin
            @(negedge Clk);
            InValid = 1'b1; TargetPC = t; CurrentPC = c; Link = l;
            #2;
            if (InReady) begin
                push(t, c, l);
                done = 1;
            end else if (++n > 200) begin
                chk("send_timeout", 32'(InReady), 32'd1);
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            InValid = 1'b0;
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge Clk);
            InValid = 1'b0;
            n++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
        @(negedge Clk);
        #4;
    endtask

    localparam logic [31:0] CUR = 32'h0040_0004;

    initial begin
        int          n;
        logic [31:0] t, c;
        // Reset state
        repeat (3) @(negedge Clk);
        #3;
        chk("rst_inready", 32'(InReady), 32'd0);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        chk("rst_errcount", 32'(ErrCount), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        #3;
        chk("release_inready", 32'(InReady), 32'd1);

        // J / JAL encodings with latency check
        chk_lat = 1;
        send(32'h0040_0020, CUR, 1'b0);
        wait_empty();
        chk("j_encode", last_instr, 32'h0810_0008);
        send(32'h0040_0020, CUR, 1'b1);
        wait_empty();
        chk("jal_encode", last_instr, 32'h0C10_0008);

        // Error cases, then saturation
        send(32'h0040_0022, CUR, 1'b0);
        send(32'h1000_0000, CUR, 1'b1);
        send(32'h1000_0002, CUR, 1'b0);
        wait_empty();
`ifdef JUMP_ENCODE_ERRCNT_EN
        chk("errcount_three", 32'(ErrCount), 32'd3);
`else
        chk("errcount_tied", 32'(ErrCount), 32'd0);
`endif
        send(32'h0040_0021, CUR, 1'b0);
        send(32'h2000_0000, CUR, 1'b1);
        wait_empty();
`ifdef JUMP_ENCODE_ERRCNT_EN
        chk("errcount_sat", 32'(ErrCount), 32'(CMAX));
`else
        chk("errcount_tied2", 32'(ErrCount), 32'd0);
`endif
        chk_lat = 0;

        // Back-pressure: 4 back-to-back requests, consumer stalled for 5 cycles
        OutReady = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge Clk);
            InValid = 1'b1;
            TargetPC = 32'h0040_0100 + 32'(n) * 4; CurrentPC = CUR; Link = n[0];
            #2;
            if (InReady) begin
                push(TargetPC, CurrentPC, Link);
                n++;
            end
        end
        chk("bp_accepted", 32'(n), 32'd2);
        chk("bp_inready", 32'(InReady), 32'd0);
        InValid = 1'b0;
        OutReady = 1'b1;
        while (n < 4) begin
            send(32'h0040_0100 + 32'(n) * 4, CUR, n[0]);
            n++;
        end
        wait_empty();

        // Mid-operation reset with S1 and S2 full
        OutReady = 1'b0;
        send(32'h0040_0200, CUR, 1'b0);
        send(32'h0040_0300, CUR, 1'b1);
        @(negedge Clk);
        Reset = 1'b0;
        InValid = 1'b0;
        #1;
        chk("midrst_outvalid", 32'(OutValid), 32'd0);
        chk("midrst_errcount", 32'(ErrCount), 32'd0);
        chk("midrst_inready", 32'(InReady), 32'd0);
        q.delete();
        exp_cnt = 0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        OutReady = 1'b1;
        #3;
        chk("midrst_release_inready", 32'(InReady), 32'd1);
        idle(6);

        // Randomised traffic with random consumer stalls
        rand_mode = 1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                c = $urandom;
                t = $urandom;
                if ($urandom_range(0, 3) != 0) t[31:28] = c[31:28];
                if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
                send(t, c, 1'($urandom_range(0, 1)));
            end
        end
        idle(1);
        rand_mode = 0;
        @(negedge Clk);
        OutReady = 1'b1;
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/jump_encode.md
JUMP_ENCODE -- requirements
Module: jump_encode

Interface
REQ-001 SHALL have parameter ERRCNT_W, default 8, width of the saturating error counter.
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state on rising edge.
REQ-003 SHALL have port Reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port InValid, input, 1 bit, a request is presented.
REQ-005 SHALL have port InReady, output, 1 bit, the block accepts a request this cycle.
REQ-006 SHALL have port TargetPC, input, 32 bits, jump destination address.
REQ-007 SHALL have port CurrentPC, input, 32 bits, PC+4 of the jump slot; only bits 31:28 are used.
REQ-008 SHALL have port Link, input, 1 bit: 1 = JAL (opcode 6'b000011), 0 = J (opcode 6'b000010).
REQ-009 SHALL have port OutValid, output, 1 bit, Instruction/Error are valid.
REQ-010 SHALL have port OutReady, input, 1 bit, the consumer accepts the output.
REQ-011 SHALL have port Instruction, output, 32 bits, encoded J-format word.
REQ-012 SHALL have port Error, output, 2 bits: bit0 = TargetPC[1:0] nonzero; bit1 = TargetPC[31:28] differs from CurrentPC[31:28].
REQ-013 SHALL have port ErrCount, output, ERRCNT_W bits, number of errored outputs accepted.

Function
REQ-014 SHALL transfer a request when InValid and InReady are both 1 on a rising edge.
REQ-015 SHALL transfer an output when OutValid and OutReady are both 1 on a rising edge.
REQ-016 SHALL be a 2-stage pipeline:
- S1 registers TargetPC[31:2], Link and both error checks.
- S2 registers Instruction and Error.
REQ-017 SHALL raise OutValid exactly 2 cycles after acceptance when OutReady stays 1.
REQ-018 SHALL sustain 1 transfer per cycle under continuous InValid=1, OutReady=1.
REQ-019 SHALL hold S2 = !OutValid || OutReady; S1 advances when S1 is empty or S2 advances; InReady = !S1 valid || S2 advance.
REQ-020 SHALL keep Instruction, Error and OutValid stable while OutValid=1 and OutReady=0.
REQ-021 SHALL form Instruction = {opcode, TargetPC[27:2]} when Error==2'b00.
REQ-022 SHALL output Instruction = 32'h0000_0000 (NOP) when Error != 2'b00.
REQ-023 SHALL set both Error bits independently; both may be 1.
REQ-024 SHALL keep InReady combinational in OutReady; there is no path from InValid to InReady.
REQ-025 SHALL increment ErrCount on each output transfer with Error != 0, saturating at all-ones.
REQ-026 SHALL reproduce TargetPC exactly when {CurrentPC[31:28], Instruction[25:0], 2'b00} is evaluated on any error-free output.
REQ-027 SHALL lose no data and duplicate no data across any stall pattern.

Reset
REQ-028 SHALL, while Reset=0, asynchronously clear: S1/S2 valid, OutValid=0, Instruction=0, Error=0, ErrCount=0.
REQ-029 SHALL drive InReady=0 during reset and 1 in the first cycle after release.
REQ-030 SHALL, on reset mid-operation, discard in-flight requests, emit no output for them and clear ErrCount.
REQ-031 SHALL deassert reset in a way that is safe for the synchronous domain; release timing is the integrator's responsibility.

Configuration
REQ-032 SHALL compile the error counter in when macro JUMP_ENCODE_ERRCNT_EN is defined.
REQ-033 SHALL, without JUMP_ENCODE_ERRCNT_EN, tie ErrCount to 0 and infer no counter flops; all other behaviour is identical.

Verification
REQ-034 SHALL verify J encoding: TargetPC=32'h0040_0020, CurrentPC=32'h0040_0004, Link=0 -> Instruction=32'h0810_0008, Error=0, OutValid 2 cycles later.
REQ-035 SHALL verify JAL encoding: same inputs with Link=1 -> Instruction=32'h0C10_0008.
REQ-036 SHALL verify errors:
- TargetPC=32'h0040_0022 -> Error=2'b01, Instruction=0.
- TargetPC=32'h1000_0000 with CurrentPC=32'h0040_0004 -> Error=2'b10.
- TargetPC=32'h1000_0002 -> Error=2'b11.
- ErrCount=3 after those three (macro defined).
REQ-037 SHALL verify back-pressure: 4 back-to-back requests with OutReady=0 for 5 cycles -> InReady=0 after 2 accepted; all 4 outputs emerge in order once OutReady=1.
REQ-038 SHALL verify saturation: with ERRCNT_W=2, 5 errored transfers -> ErrCount=3.
REQ-039 SHALL verify mid-operation reset: Reset=0 pulse with S1/S2 full -> OutValid=0 immediately, ErrCount=0, no stale output after release.
